// File: rtl/bf16_product_normalizer_if.sv
`default_nettype none
// ============================================================================
// Module      : bf16_product_normalizer_if
// Description : Operand/result handshake bundle for the BF16 product
//               normalizer. The upstream/downstream driver uses the master
//               modport and the normalizer uses the slave modport.
//               Ports (slave view):
//                 in_valid/in_ready        operand handshake
//                 in_mults, in_multc       carry-save mantissa product
//                 in_sign, in_exp, in_zero sign, biased exponent sum, zero flag
//                 out_valid/out_ready      result handshake
//                 out_result, out_flags    BF16 result, {ovf, unf, inexact}
// Revision    : 1.0 - initial release
// ============================================================================
interface bf16_product_normalizer_if #(
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [16:0]      in_mults;
    logic [16:0]      in_multc;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic             in_zero;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [2:0]       out_flags;

    modport master (
        output in_valid, in_mults, in_multc, in_sign, in_exp, in_zero, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_mults, in_multc, in_sign, in_exp, in_zero, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface
`default_nettype wire

// File: rtl/bf16_product_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : bf16_product_normalizer
// Description : Two-stage valid/ready pipeline that resolves a carry-save
//               mantissa product, normalizes it, rounds to nearest-even and
//               packs a BF16 result with overflow/underflow/inexact flags.
//               Ports:
//                 clk  - clock, rising edge
//                 rst  - asynchronous active-high reset
//                 bus  - slave side of bf16_product_normalizer_if
// Revision    : 1.0 - initial release
// ============================================================================
module bf16_product_normalizer #(
    parameter int EXP_W = 10
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    bf16_product_normalizer_if.slave  bus
);

    localparam logic signed [EXP_W-1:0] c_EXP_OVF  = EXP_W'(255);
    localparam logic signed [EXP_W-1:0] c_EXP_ZERO = '0;

    // ---------------- Stage 1 registers ----------------
    logic                    r_s1_valid;
    logic [15:0]             r_s1_p;
    logic                    r_s1_sign;
    logic signed [EXP_W-1:0] r_s1_exp;
    logic                    r_s1_zero;

    // ---------------- Stage 2 registers ----------------
    logic                    r_s2_valid;
    logic [15:0]             r_s2_result;
    logic [2:0]              r_s2_flags;

    // ---------------- Handshake ----------------
    logic w_s1_advance;
    logic w_in_fire;

    // S1 may move into S2 whenever S2 is empty or is being drained this cycle.
    assign w_s1_advance  = r_s1_valid && (!r_s2_valid || bus.out_ready);
    assign bus.in_ready  = !r_s1_valid || w_s1_advance;
    assign w_in_fire     = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out_result = r_s2_result;
    assign bus.out_flags  = r_s2_flags;

    // Carry-propagate add of the carry-save pair; bit 16 of the sum is
    // discarded by the truncating cast.
    logic [15:0] w_p;
    assign w_p = 16'(bus.in_mults + {bus.in_multc, 1'b0});

    // ---------------- Normalize and round (from S1) ----------------
    logic                    w_hi;
    logic [6:0]              w_m;
    logic                    w_g;
    logic                    w_s;
    logic                    w_inc;
    logic [7:0]              w_m_rnd;
    logic signed [EXP_W-1:0] w_e_rnd;
    logic                    w_inexact;
    logic                    w_ovf;
    logic                    w_unf;
    logic [15:0]             w_result;
    logic [2:0]              w_flags;

    assign w_hi = r_s1_p[15];

    always_comb begin
        w_m = r_s1_p[13:7];
        w_g = r_s1_p[6];
        w_s = |r_s1_p[5:0];
        if (w_hi) begin
            w_m = r_s1_p[14:8];
            w_g = r_s1_p[7];
            w_s = |r_s1_p[6:0];
        end
    end

    assign w_inc     = w_g && (w_s || w_m[0]);
    // Bit 7 of the rounded mantissa is the carry out of 7'h7F + 1.
    assign w_m_rnd   = {1'b0, w_m} + {7'd0, w_inc};
    assign w_e_rnd   = r_s1_exp + EXP_W'(w_hi) + EXP_W'(w_m_rnd[7]);
    assign w_inexact = w_g || w_s;
    assign w_ovf     = (w_e_rnd >= c_EXP_OVF);
    assign w_unf     = (w_e_rnd <= c_EXP_ZERO);

    always_comb begin
        w_result = {r_s1_sign, w_e_rnd[7:0], w_m_rnd[6:0]};
        w_flags  = {2'b00, w_inexact};
        if (r_s1_zero) begin
            w_result = {r_s1_sign, 15'h0000};
            w_flags  = 3'b000;
        end else if (w_ovf) begin
            w_result = {r_s1_sign, 8'hFF, 7'h00};
            w_flags  = 3'b101;
        end else if (w_unf) begin
            w_result = {r_s1_sign, 15'h0000};
            w_flags  = 3'b011;
        end
    end

    // ---------------- Stage 1 ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_zero  <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_p     <= w_p;
                r_s1_sign  <= bus.in_sign;
                r_s1_exp   <= bus.in_exp;
                r_s1_zero  <= bus.in_zero;
            end else if (w_s1_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // ---------------- Stage 2 ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_flags  <= '0;
        end else begin
            if (w_s1_advance) begin
                r_s2_valid  <= 1'b1;
                r_s2_result <= w_result;
                r_s2_flags  <= w_flags;
            end else if (r_s2_valid && bus.out_ready) begin
                r_s2_valid  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_product_normalizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bf16_product_normalizer
// Description : Self-checking bench for bf16_product_normalizer. Directed
//               vectors, randomized traffic against an arithmetic reference
//               model, backpressure and asynchronous reset scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bf16_product_normalizer;

    localparam int EXP_W = 10;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bf16_product_normalizer_if #(.EXP_W(EXP_W)) bus ();

    bf16_product_normalizer #(.EXP_W(EXP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: value-level rounding of P/2^shift, returns {flags, result}.
    function automatic logic [18:0] ref_model(input int ms, input int mc,
                                              input bit sign, input int exp,
                                              input bit zero);
        int p, sh, frac, rem, half, e;
        bit inexact;
        p = (ms + 2 * mc) % 65536;
        if (p >= 32768) begin sh = 8; e = exp + 1; end
        else            begin sh = 7; e = exp;     end
        frac    = (p >> sh) % 128;
        rem     = p % (1 << sh);
        half    = 1 << (sh - 1);
        inexact = (rem != 0);
        if (rem > half || (rem == half && (frac % 2) == 1)) frac = frac + 1;
        if (frac == 128) begin frac = 0; e = e + 1; end
        if (zero)     return {3'b000, sign, 15'h0000};
        if (e >= 255) return {3'b101, sign, 15'h7F80};
        if (e <= 0)   return {3'b011, sign, 15'h0000};
        return {2'b00, inexact, sign, e[7:0], frac[6:0]};
    endfunction

    task automatic drive(input int ms, input int mc, input bit sign,
                         input int exp, input bit zero);
        bus.in_mults = 17'(ms);
        bus.in_multc = 17'(mc);
        bus.in_sign  = sign;
        bus.in_exp   = EXP_W'(exp);
        bus.in_zero  = zero;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset;
        #2;
        total++;
        if ({bus.out_valid, bus.out_result, bus.out_flags} !== 20'h0) begin
            bad++;
            $display("FAIL reset_hold: got v=%b r=%h f=%b want 0/0000/000",
                     bus.out_valid, bus.out_result, bus.out_flags);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    typedef struct {
        int ms; int mc; bit sign; int exp; bit zero;
        logic [15:0] res; logic [2:0] fl;
    } vec_t;

    task automatic test_directed;
        vec_t v[10];
        v[0] = '{32'h04000, 0,         0, 127, 0, 16'h3F80, 3'b000};
        v[1] = '{32'h03000, 32'h00800, 0, 127, 0, 16'h3F80, 3'b000};
        v[2] = '{32'h09000, 0,         0, 127, 0, 16'h4010, 3'b000};
        v[3] = '{32'h040C0, 0,         0, 127, 0, 16'h3F82, 3'b001};
        v[4] = '{32'h04040, 0,         0, 127, 0, 16'h3F80, 3'b001};
        v[5] = '{32'h0FFFF, 0,         0, 127, 0, 16'h4080, 3'b001};
        v[6] = '{32'h08000, 0,         0, 254, 0, 16'h7F80, 3'b101};
        v[7] = '{32'h04000, 0,         0, 0,   0, 16'h0000, 3'b011};
        v[8] = '{32'h04000, 0,         1, 127, 1, 16'h8000, 3'b000};
        v[9] = '{32'h04000, 0,         1, 127, 0, 16'hBF80, 3'b000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(v[i].ms, v[i].mc, v[i].sign, v[i].exp, v[i].zero);
            bus.in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (bus.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL dir%0d_in_ready: got %b want 1", i, bus.in_ready);
            end
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL dir%0d_latency_early: out_valid=%b want 0", i, bus.out_valid);
            end
            @(posedge clk); #1;
            total++;
            if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, v[i].res, v[i].fl}) begin
                bad++;
                $display("FAIL dir%0d_result: got v=%b r=%h f=%b want v=1 r=%h f=%b",
                         i, bus.out_valid, bus.out_result, bus.out_flags, v[i].res, v[i].fl);
            end
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random;
        logic [18:0] q[$];
        logic [18:0] want;
        logic [15:0] hres;
        logic [2:0]  hfl;
        bit held, fired, sg, zr;
        int ms, mc, ex;
        held = 0; fired = 0;
        ms = 0; mc = 0; ex = 0; sg = 0; zr = 0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (held) begin
                total++;
                if ({bus.out_valid, bus.out_result, bus.out_flags} !== {1'b1, hres, hfl}) begin
                    bad++;
                    $display("FAIL rand_hold_stable: got v=%b r=%h f=%b want v=1 r=%h f=%b",
                             bus.out_valid, bus.out_result, bus.out_flags, hres, hfl);
                end
            end
            if (!bus.in_valid || fired) begin
                ms = int'($urandom_range(0, 131071));
                mc = int'($urandom_range(0, 131071));
                sg = 1'($urandom_range(0, 1));
                zr = ($urandom_range(0, 7) == 0);
                case ($urandom_range(0, 3))
                    0:       ex = int'($urandom_range(245, 256));
                    1:       ex = int'($urandom_range(0, 6)) - 3;
                    default: ex = int'($urandom_range(0, 509)) - 127;
                endcase
                drive(ms, mc, sg, ex, zr);
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            fired = bus.in_valid && bus.in_ready;
            if (fired) q.push_back(ref_model(ms, mc, sg, ex, zr));
            held = bus.out_valid && !bus.out_ready;
            hres = bus.out_result;
            hfl  = bus.out_flags;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_extra_output: got r=%h with no pending input", bus.out_result);
                end else begin
                    want = q.pop_front();
                    if ({bus.out_flags, bus.out_result} !== want) begin
                        bad++;
                        $display("FAIL rand_result: got r=%h f=%b want r=%h f=%b",
                                 bus.out_result, bus.out_flags, want[15:0], want[18:16]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL rand_drain_extra: got r=%h with no pending input", bus.out_result);
                end else begin
                    want = q.pop_front();
                    if ({bus.out_flags, bus.out_result} !== want) begin
                        bad++;
                        $display("FAIL rand_drain_result: got r=%h f=%b want r=%h f=%b",
                                 bus.out_result, bus.out_flags, want[15:0], want[18:16]);
                    end
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL rand_drain_empty: %0d results missing, want 0", q.size());
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_backpressure;
        int ms[5], ex[5];
        logic [18:0] want[5];
        logic [15:0] hres;
        int idx, got;
        bit started;
        for (int i = 0; i < 5; i++) begin
            ms[i]   = 32'h04000 + i * 32'h00100;
            ex[i]   = 100 + i;
            want[i] = ref_model(ms[i], 0, 0, ex[i], 0);
        end
        idx = 0;
        hres = '0;
        bus.out_ready = 1'b0;
        drive(ms[0], 0, 0, ex[0], 0);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 2) hres = bus.out_result;
            if (cyc == 3) begin
                total++;
                if ({bus.out_valid, bus.out_result} !== {1'b1, hres}) begin
                    bad++;
                    $display("FAIL bp_hold_stable: got v=%b r=%h want v=1 r=%h",
                             bus.out_valid, bus.out_result, hres);
                end
                total++;
                if (bus.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_in_ready_low: got %b want 0", bus.in_ready);
                end
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            drive(ms[idx], 0, 0, ex[idx], 0);
        end
        total++;
        if (idx != 2) begin
            bad++;
            $display("FAIL bp_accept_count: got %0d want 2", idx);
        end
        bus.out_ready = 1'b1;
        got = 0;
        started = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                started = 1;
                total++;
                if ({bus.out_flags, bus.out_result} !== want[got]) begin
                    bad++;
                    $display("FAIL bp_order%0d: got r=%h f=%b want r=%h f=%b", got,
                             bus.out_result, bus.out_flags, want[got][15:0], want[got][18:16]);
                end
                got++;
            end else if (started) begin
                total++;
                bad++;
                $display("FAIL bp_gap: out_valid=0 after %0d results, want 1", got);
            end
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk); #1;
            if (idx < 5) drive(ms[idx], 0, 0, ex[idx], 0);
            else bus.in_valid = 1'b0;
        end
        total++;
        if (got != 5) begin
            bad++;
            $display("FAIL bp_result_count: got %0d want 5", got);
        end
        bus.in_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_async_reset;
        logic [18:0] want;
        int n;
        bus.out_ready = 1'b0;
        drive(32'h05000, 0, 0, 120, 0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(32'h06000, 0, 1, 121, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL arst_full: got out_valid=%b in_ready=%b want 1/0",
                     bus.out_valid, bus.in_ready);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({bus.out_valid, bus.out_result, bus.out_flags} !== 20'h0) begin
            bad++;
            $display("FAIL arst_immediate: got v=%b r=%h f=%b want 0/0000/000",
                     bus.out_valid, bus.out_result, bus.out_flags);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL arst_after: got out_valid=%b in_ready=%b want 0/1",
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        want = ref_model(32'h07000, 0, 0, 130, 0);
        drive(32'h07000, 0, 0, 130, 0);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                n++;
                total++;
                if ({bus.out_flags, bus.out_result} !== want) begin
                    bad++;
                    $display("FAIL arst_new_result: got r=%h f=%b want r=%h f=%b",
                             bus.out_result, bus.out_flags, want[15:0], want[18:16]);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (n != 1) begin
            bad++;
            $display("FAIL arst_result_count: got %0d want 1", n);
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bf16_product_normalizer.md
# bf16_product_normalizer

Downstream stage of the variable-precision BFloat16 mantissa multiplier. It takes the multiplier's carry-save mantissa product, a precomputed exponent sum, the result sign and a zero flag. It resolves the carry-save pair with a carry-propagate add, normalizes, rounds to nearest-even and packs a BF16 result with overflow, underflow and inexact flags. It is a 2-stage valid/ready pipeline with one result per cycle throughput.

## Interface
- `EXP_W`, default 10: width of the signed exponent path. Must be ≥10 so that a sum of 0..509 plus +2 never wraps.
- `clk` input, 1: clock. All state changes on the rising edge.
- `rst` input, 1: reset. Asynchronous, active-high, and the only reset in the block.
- `in_valid` input, 1: upstream offers an operand set.
- `in_ready` output, 1: block accepts this cycle. A transfer occurs when `in_valid && in_ready`.
- `in_mults` input, 17: carry-save sum vector from the mantissa multiplier.
- `in_multc` input, 17: carry-save carry vector. Its weight is shifted left by 1.
- `in_sign` input, 1: result sign, equal to sa XOR sb.
- `in_exp` input, EXP_W: signed value ea + eb − 127, biased.
- `in_zero` input, 1: either operand is zero.
- `out_valid` output, 1: result available.
- `out_ready` input, 1: downstream accepts. A transfer occurs when `out_valid && out_ready`.
- `out_result` output, 16: BF16 value {sign, exp[7:0], frac[6:0]}.
- `out_flags` output, 3: {overflow, underflow, inexact}.

## Operation
- Stage 1 (S1) captures the following on the accept edge:
  - P = (in_mults + (in_multc << 1)) mod 2^17. P[16] is ignored.
  - in_sign, in_exp, in_zero.
- Stage 2 (S2) captures the normalized, rounded and packed result from S1.
- Normalization:
  - If P[15]=1: m=P[14:8], g=P[7], s=|P[6:0], e=exp+1.
  - Otherwise, including P[15:14]=00: m=P[13:7], g=P[6], s=|P[5:0], e=exp.
- Rounding is RNE: increment when g && (s || m[0]).
  - If m=7'h7F increments, it becomes 7'h00 and e=e+1.
  - inexact = g | s.
- Exception checks, evaluated in priority order after rounding:
  1. in_zero: result {sign,15'h0}, flags 000.
  2. e ≥ 255: result {sign,8'hFF,7'h0}, overflow=1, inexact=1.
  3. e ≤ 0: result {sign,15'h0}, underflow=1, inexact=1. No subnormals are produced.
  4. Otherwise: result {sign,e[7:0],m}, inexact as computed.
- Truncation applied upstream by the mask is treated as exact data. The block does not infer inexactness from it.

## Timing
- Reset values: `out_valid`=0, `out_result`=16'h0000, `out_flags`=3'b000. S1 and S2 valid bits are 0 and payload registers are 0.
- Latency is 2 edges. An input accepted at edge N produces `out_valid`=1 after edge N+1 (S1 at N, S2 at N+1). Throughput is 1 per cycle with no bubbles while `out_ready`=1.
- Stall rules:
  - S2 holds when `out_valid && !out_ready`. `out_result` and `out_flags` stay stable while held.
  - S1 advances when S2 is empty or S2 is transferring.
  - `in_ready` = !s1_valid || s1_advance. It is combinationally dependent on `out_ready`, with no registered skid.
- Simultaneous output transfer and S1 advance in the same cycle is required. No cycle is lost.
- An empty S1 with a valid S2 still accepts input.
- Asserting `rst` mid-operation clears both stages immediately, without waiting for an edge. In-flight data is discarded and `in_ready` becomes 1 once `rst` is released.
- Ordering is strictly FIFO. No result is dropped or duplicated under any `out_ready` pattern.

## Test plan
- 1.0×1.0: mults=17'h04000, multc=0, exp=127, sign=0 → 0x3F80, flags 000, `out_valid` two edges after accept.
- Split carry-save: mults=17'h03000, multc=17'h00800 → P=0x4000 → 0x3F80. Also 1.5×1.5 with P=0x9000, exp=127 → 0x4010 (2.25), flags 000.
- Rounding, exp=127:
  - P=0x40C0 → frac 0x02, inexact=1.
  - P=0x4040 → tie-even, frac 0x00, inexact=1.
  - P=0xFFFF → mantissa carry, result 0x4080, inexact=1.
- Exceptions:
  - exp=254 with P=0x8000 → 0x7F80, flags 101.
  - exp=0 with P=0x4000 → 0x0000, flags 011.
  - sign=1 with in_zero=1 → 0x8000, flags 000.
- Backpressure: stream 5 distinct inputs with `out_ready` low for 4 cycles. Exactly 2 inputs are accepted and `in_ready` then drops. After release, all 5 results emerge in order with no gaps, and outputs stay stable while held.
- Reset: assert `rst` asynchronously between edges with both stages full. `out_valid` goes 0 immediately. After deassertion, a new input yields only its own result.
